submatrix_ring_buffer: RTL and testbench
========================================

Name: submatrix_ring_buffer

Overview:
- Parametrised multi-slot successor to the single-register submatrix holder.
- Holds up to DEPTH submatrices. Each slot moves through a fixed sequence: loaded from the submatrix generator, issued to the encryptor, overwritten in place by the encrypted result, drained to the encrypted-image generator.
- All three stages run concurrently on different slots, so the encryptor pipeline can stay full.
- Strict in-order: data leaves the block in load order.

Parameters:
- DATA_W, 16, width of one submatrix in bits.
- DEPTH, 4, number of slots. Range 1..16; need not be a power of two. DEPTH=1 gives the legacy single-register behaviour.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- load_valid  in  1  generator presents a new submatrix.
- load_data  in  DATA_W  unencrypted submatrix.
- load_ready  out  1  a free slot exists at the write pointer.
- enc_in_valid  out  1  the slot at the issue pointer holds raw data.
- enc_in_data  out  DATA_W  raw submatrix to the encryptor.
- enc_in_ready  in  1  encryptor accepts enc_in_data.
- enc_out_valid  in  1  encryptor returns one result, in order.
- enc_out_data  in  DATA_W  encrypted submatrix.
- out_valid  out  1  the slot at the read pointer holds encrypted data.
- out_data  out  DATA_W  encrypted submatrix to the image generator.
- out_ready  in  1  image generator consumes out_data.
- occupancy  out  $clog2(DEPTH+1)  number of non-EMPTY slots.
- err_unexpected  out  1  sticky; an encryptor result arrived with no slot ISSUED.
- stat_done  out  16  drained-submatrix count (STATS_EN only).
- stat_stall  out  16  stall-cycle count (STATS_EN only).

Behaviour:
- Reset is asynchronous and active-low (resetN). On assertion:
  - all slots go to EMPTY and slot data is zeroed;
  - the wr/iss/ret/rd pointers are set to 0;
  - load_ready=1, every other output is 0 (including occupancy, err_unexpected and the stats).
  - Reset mid-operation discards all contents. Results still in flight in the encryptor are not tracked; if they return after reset they set err_unexpected. The encryptor must be reset together with this block.
- Per-slot state: EMPTY → RAW → ISSUED → DONE → EMPTY. All state is registered.
- Load: when load_valid && load_ready, slot[wr] takes load_data and becomes RAW; wr advances.
- Issue: enc_in_valid = (slot[iss]==RAW) and enc_in_data = slot[iss].data. On enc_in_valid && enc_in_ready the slot becomes ISSUED and iss advances.
- Return:
  - If enc_out_valid and slot[ret]==ISSUED, the slot data is overwritten with enc_out_data, the slot becomes DONE and ret advances.
  - Otherwise enc_out_valid is ignored and err_unexpected is set. It stays set until reset.
- Drain: out_valid = (slot[rd]==DONE) and out_data = slot[rd].data. On out_valid && out_ready the slot becomes EMPTY, its data is kept, and rd advances.
- Output decoding: load_ready, enc_in_valid and out_valid depend only on registered state, never combinationally on the ready/valid inputs.
- Pointers: each pointer wraps from DEPTH-1 to 0.
- Latency:
  - load → enc_in_valid: 1 cycle;
  - enc_out_valid → out_valid: 1 cycle;
  - the encryptor must have ≥1 cycle latency, so a result in the issue cycle is flagged as unexpected;
  - minimum load-to-drain: 3 cycles plus the encryptor latency.
- Simultaneous events: load, issue, return and drain may all fire in one cycle on different slots.
  - A slot freed by drain is loadable no earlier than the next cycle (no same-cycle bypass).
  - With DEPTH=1 this gives at most one submatrix per 3 + encryptor-latency cycles.
- Full: all slots non-EMPTY forces load_ready=0. Empty: occupancy=0, enc_in_valid=0, out_valid=0.
- occupancy: +1 on load, −1 on drain, unchanged when both fire in the same cycle.

Optional Feature:
- Macro: SUBMATRIX_STATS_EN.
- When defined:
  - stat_done increments on each drain;
  - stat_stall increments each cycle with load_valid && !load_ready;
  - both saturate at 0xFFFF and clear on reset.
- When undefined: both ports are tied to 0 and no counter logic exists.

Decomposition:
- Package submatrix_pkg holds:
  - the slot-state enum (SLOT_EMPTY, SLOT_RAW, SLOT_ISSUED, SLOT_DONE, 2 bits);
  - the default SUBMATRIX_W=16;
  - a pointer-increment-with-wrap function.
- Sub-module submatrix_slot: one state register plus data register, with load/issue/writeback/drain strobes. Instantiated DEPTH times in a generate loop.
- Top level holds the pointers, the output muxes, occupancy, the error flag and the stats.

Test Plan:
- Reset then idle → load_ready=1, occupancy=0, all valids 0. Assert resetN=0 mid-stream with 3 slots full → occupancy=0 immediately, asynchronously.
- DEPTH=4; load 0x1111, 0x2222, 0x3333, 0x4444 with enc_in_ready=0 → load_ready=0 after the 4th load, occupancy=4. A 5th load_valid holds and stat_stall counts.
- Encryptor model = XOR 0xA5A5 with 2-cycle latency, out_ready=1 → out_data sequence 0xB4B4, 0x8787, 0x9696, 0xE1E1, in order.
- Continuous load, issue and drain with out_ready toggling 1010 → no loss and no reorder over 100 random words; occupancy never exceeds 4.
- enc_out_valid pulsed with nothing ISSUED → err_unexpected=1 and stays 1; slot contents unchanged.
- DEPTH=1, 1-cycle encryptor → one submatrix every 4 cycles; with SUBMATRIX_STATS_EN, stat_done=10 after 10 drains.

Source files
------------

// File: rtl/submatrix_pkg.sv
// Shared types and helpers for the submatrix ring buffer: slot-state encoding,
// default submatrix width and the wrapping pointer increment.
package submatrix_pkg;

  localparam int SUBMATRIX_W = 16;
  localparam int PTR_W       = 4;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY  = 2'd0,
    SLOT_RAW    = 2'd1,
    SLOT_ISSUED = 2'd2,
    SLOT_DONE   = 2'd3
  } slot_state_e;

  // Pointers are sized for the largest ring; depth need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t ptr, input int unsigned depth);
    return (ptr == ptr_t'(depth - 1)) ? '0 : ptr + ptr_t'(1);
  endfunction

endpackage

// File: rtl/submatrix_slot.sv
// One ring-buffer slot: lifecycle state plus the submatrix it holds. The top
// level guarantees at most one strobe per slot per cycle.
module submatrix_slot
  import submatrix_pkg::*;
#(
  parameter int DATA_W = SUBMATRIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_issue,
  input  logic              i_writeback,
  input  logic              i_drain,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic [DATA_W-1:0] i_wb_data,
  output slot_state_e       o_state,
  output logic [DATA_W-1:0] o_data
);

  slot_state_e       r_state;
  logic [DATA_W-1:0] r_data;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      // NOTE: slot data is cleared on reset too, so no stale submatrix is ever visible.
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= SLOT_RAW;
      r_data  <= i_load_data;
    end else if (i_issue) begin
      r_state <= SLOT_ISSUED;
    end else if (i_writeback) begin
      r_state <= SLOT_DONE;
      r_data  <= i_wb_data;
    end else if (i_drain) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign o_state = r_state;
  assign o_data  = r_data;

endmodule

// File: rtl/submatrix_ring_buffer.sv
// In-order multi-slot buffer between submatrix generator, encryptor and image
// generator. Optional statistics counters are enabled by SUBMATRIX_STATS_EN.
module submatrix_ring_buffer
  import submatrix_pkg::*;
#(
  parameter  int DATA_W = SUBMATRIX_W,
  parameter  int DEPTH  = 4,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              enc_in_valid,
  output logic [DATA_W-1:0] enc_in_data,
  input  logic              enc_in_ready,
  input  logic              enc_out_valid,
  input  logic [DATA_W-1:0] enc_out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic              err_unexpected,
  output logic [15:0]       stat_done,
  output logic [15:0]       stat_stall
);

  ptr_t             r_wr, r_iss, r_ret, r_rd;
  logic [OCC_W-1:0] r_occ;
  logic             r_err;

  slot_state_e       w_state [DEPTH];
  logic [DATA_W-1:0] w_data  [DEPTH];
  slot_state_e       w_wr_state, w_iss_state, w_ret_state, w_rd_state;
  logic [DATA_W-1:0] w_iss_data, w_rd_data;
  logic              w_load, w_issue, w_ret_ok, w_drain;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_wr_state  = SLOT_EMPTY;
    w_iss_state = SLOT_EMPTY;
    w_ret_state = SLOT_EMPTY;
    w_rd_state  = SLOT_EMPTY;
    w_iss_data  = '0;
    w_rd_data   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_wr == ptr_t'(i))  w_wr_state = w_state[i];
      if (r_ret == ptr_t'(i)) w_ret_state = w_state[i];
      if (r_iss == ptr_t'(i)) begin
        w_iss_state = w_state[i];
        w_iss_data  = w_data[i];
      end
      if (r_rd == ptr_t'(i)) begin
        w_rd_state = w_state[i];
        w_rd_data  = w_data[i];
      end
    end
  end

  // Handshake outputs decode registered slot state only.
  assign load_ready   = (w_wr_state == SLOT_EMPTY);
  assign enc_in_valid = (w_iss_state == SLOT_RAW);
  assign enc_in_data  = w_iss_data;
  assign out_valid    = (w_rd_state == SLOT_DONE);
  assign out_data     = w_rd_data;

  assign w_load   = load_valid && load_ready;
  assign w_issue  = enc_in_valid && enc_in_ready;
  assign w_ret_ok = enc_out_valid && (w_ret_state == SLOT_ISSUED);
  assign w_drain  = out_valid && out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    submatrix_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clock),
      .rst_n       (resetN),
      .i_load      (w_load   && (r_wr  == ptr_t'(g))),
      .i_issue     (w_issue  && (r_iss == ptr_t'(g))),
      .i_writeback (w_ret_ok && (r_ret == ptr_t'(g))),
      .i_drain     (w_drain  && (r_rd  == ptr_t'(g))),
      .i_load_data (load_data),
      .i_wb_data   (enc_out_data),
      .o_state     (w_state[g]),
      .o_data      (w_data[g])
    );
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wr  <= '0;
      r_iss <= '0;
      r_ret <= '0;
      r_rd  <= '0;
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_load)   r_wr  <= ptr_inc(r_wr,  DEPTH);
      if (w_issue)  r_iss <= ptr_inc(r_iss, DEPTH);
      if (w_ret_ok) r_ret <= ptr_inc(r_ret, DEPTH);
      if (w_drain)  r_rd  <= ptr_inc(r_rd,  DEPTH);
      // A result with no ISSUED slot at the return pointer is dropped and flagged.
      if (enc_out_valid && !w_ret_ok) r_err <= 1'b1;
      if (w_load && !w_drain)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_load && w_drain) r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy      = r_occ;
  assign err_unexpected = r_err;

`ifdef SUBMATRIX_STATS_EN
  logic [15:0] r_stat_done, r_stat_stall;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_stat_done  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_drain && (r_stat_done != 16'hFFFF))
        r_stat_done <= r_stat_done + 16'd1;
      if (load_valid && !load_ready && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_done  = r_stat_done;
  assign stat_stall = r_stat_stall;
`else
  assign stat_done  = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_submatrix_ring_buffer.sv
// Scoreboard bench for submatrix_ring_buffer: a DEPTH=4 instance with a 2-cycle
// XOR encryptor and a DEPTH=1 instance with a 1-cycle XOR encryptor.
module tb_submatrix_ring_buffer;

  localparam logic [15:0] KEY = 16'hA5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        load_valid, load_ready, enc_in_valid, enc_in_ready;
  logic        enc_out_valid = 1'b0, out_valid, out_ready, err_unexpected;
  logic [15:0] load_data, enc_in_data, enc_out_data = '0, out_data, stat_done, stat_stall;
  logic [2:0]  occupancy;

  logic        d1_load_valid, d1_load_ready, d1_enc_in_valid, d1_enc_in_ready;
  logic        d1_enc_out_valid = 1'b0, d1_out_valid, d1_out_ready, d1_err;
  logic [15:0] d1_load_data, d1_enc_in_data, d1_enc_out_data = '0, d1_out_data;
  logic [15:0] d1_stat_done, d1_stat_stall;
  logic [0:0]  d1_occupancy;

  submatrix_ring_buffer #(.DATA_W(16), .DEPTH(4)) u_dut (
    .clock(clk), .resetN(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .enc_in_valid(enc_in_valid), .enc_in_data(enc_in_data), .enc_in_ready(enc_in_ready),
    .enc_out_valid(enc_out_valid), .enc_out_data(enc_out_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .err_unexpected(err_unexpected),
    .stat_done(stat_done), .stat_stall(stat_stall)
  );

  submatrix_ring_buffer #(.DATA_W(16), .DEPTH(1)) u_dut1 (
    .clock(clk), .resetN(rst_n),
    .load_valid(d1_load_valid), .load_data(d1_load_data), .load_ready(d1_load_ready),
    .enc_in_valid(d1_enc_in_valid), .enc_in_data(d1_enc_in_data), .enc_in_ready(d1_enc_in_ready),
    .enc_out_valid(d1_enc_out_valid), .enc_out_data(d1_enc_out_data),
    .out_valid(d1_out_valid), .out_data(d1_out_data), .out_ready(d1_out_ready),
    .occupancy(d1_occupancy), .err_unexpected(d1_err),
    .stat_done(d1_stat_done), .stat_stall(d1_stat_stall)
  );

  typedef struct {
    logic [15:0] d;
    int          due;
  } enc_item_t;

  int          n_checks = 0, n_fail = 0, cyc = 0;
  int          enc_lat = 2;
  enc_item_t   enc_q[$];
  logic [15:0] exp_q[$], got_q[$], d1_exp_q[$];
  int          m_occ = 0, max_occ = 0, n_loaded = 0, n_drained = 0;
  int          d1_drains = 0, d1_last_drain = -1;
  logic        inj_err = 1'b0, d1_pend = 1'b0;
  logic [15:0] inj_data = '0, d1_pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Encryptor model for the DEPTH=4 instance: pipelined XOR with enc_lat cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      enc_out_valid = 1'b0;
    end else begin
      if (enc_in_valid && enc_in_ready)
        enc_q.push_back(enc_item_t'{d: enc_in_data ^ KEY, due: cyc + 1 + enc_lat});
      if (inj_err) begin
        enc_out_valid = 1'b1;
        enc_out_data  = inj_data;
      end else if (enc_q.size() > 0 && enc_q[0].due == cyc + 1) begin
        enc_out_valid = 1'b1;
        enc_out_data  = enc_q[0].d;
        void'(enc_q.pop_front());
      end else begin
        enc_out_valid = 1'b0;
      end
    end
  end

  // Encryptor model for the DEPTH=1 instance: XOR with 1-cycle latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      d1_enc_out_valid = 1'b0;
      d1_pend          = 1'b0;
    end else begin
      d1_enc_out_valid = d1_pend;
      d1_enc_out_data  = d1_pend_data;
      d1_pend          = d1_enc_in_valid && d1_enc_in_ready;
      d1_pend_data     = d1_enc_in_data ^ KEY;
    end
  end

  // Stimulus side of the scoreboards: every accepted load predicts one output.
  always @(negedge clk) begin
    if (rst_n && load_valid && load_ready) begin
      exp_q.push_back(load_data ^ KEY);
      n_loaded++;
    end
    if (rst_n && d1_load_valid && d1_load_ready)
      d1_exp_q.push_back(d1_load_data ^ KEY);
  end

  // Monitors.
  always @(negedge clk) begin
    if (rst_n) begin
      check("occupancy", 32'(occupancy), m_occ);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_data: got 0x%0h with nothing expected", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got_q.push_back(out_data);
        n_drained++;
      end
      m_occ = m_occ + int'(load_valid && load_ready) - int'(out_valid && out_ready);
      if (m_occ > max_occ) max_occ = m_occ;
    end
  end

  always @(negedge clk) begin
    if (rst_n && d1_out_valid && d1_out_ready) begin
      if (d1_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL d1_out_data: got 0x%0h with nothing expected", d1_out_data);
      end else begin
        check("d1_out_data", 32'(d1_out_data), 32'(d1_exp_q.pop_front()));
      end
      if (d1_last_drain >= 0) check("d1_drain_interval", cyc - d1_last_drain, 4);
      d1_last_drain = cyc;
      d1_drains++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] fill_words [4];
    logic [15:0] xor_words  [4];
    logic [15:0] exp_stat;
    fill_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    xor_words  = '{16'hB4B4, 16'h8787, 16'h9696, 16'hE1E1};

    rst_n = 1'b0;
    load_valid = 0; load_data = '0; enc_in_ready = 0; out_ready = 0;
    d1_load_valid = 0; d1_load_data = '0; d1_enc_in_ready = 0; d1_out_ready = 0;
    #12 rst_n = 1'b1;

    // Reset then idle.
    repeat (3) step();
    @(negedge clk);
    check("idle_load_ready", load_ready, 1);
    check("idle_occupancy", 32'(occupancy), 0);
    check("idle_enc_in_valid", enc_in_valid, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_err", err_unexpected, 0);
    check("idle_enc_in_data", 32'(enc_in_data), 0);
    check("idle_out_data", 32'(out_data), 0);
    check("idle_stat_done", 32'(stat_done), 0);
    check("idle_stat_stall", 32'(stat_stall), 0);
    check("idle_d1_load_ready", d1_load_ready, 1);

    // Fill all four slots with the encryptor stalled.
    step();
    for (int k = 0; k < 4; k++) begin
      load_valid = 1'b1;
      load_data  = fill_words[k];
      step();
    end
    load_data = 16'h5555;
    @(negedge clk);
    check("full_load_ready", load_ready, 0);
    check("full_occupancy", 32'(occupancy), 4);
    check("full_enc_in_valid", enc_in_valid, 1);
    check("full_enc_in_data", 32'(enc_in_data), 32'h1111);
    repeat (3) step();
    load_valid = 1'b0;
    @(negedge clk);
`ifdef SUBMATRIX_STATS_EN
    exp_stat = 16'd3;
`else
    exp_stat = 16'd0;
`endif
    check("full_stat_stall", 32'(stat_stall), 32'(exp_stat));
    check("full_hold_occupancy", 32'(occupancy), 4);

    // Encrypt and drain in order.
    step();
    got_q.delete();
    enc_in_ready = 1'b1;
    out_ready    = 1'b1;
    for (int c = 0; c < 60 && got_q.size() < 4; c++) step();
    check("xor_drain_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check("xor_order", 32'(got_q[k]), 32'(xor_words[k]));
    @(negedge clk);
    check("xor_empty_occupancy", 32'(occupancy), 0);
    check("xor_empty_out_valid", out_valid, 0);
`ifdef SUBMATRIX_STATS_EN
    exp_stat = 16'd4;
`else
    exp_stat = 16'd0;
`endif
    check("xor_stat_done", 32'(stat_done), 32'(exp_stat));

    // Unexpected encryptor result while the only slot is still RAW.
    step();
    enc_in_ready = 1'b0;
    load_valid   = 1'b1;
    load_data    = 16'h5A5A;
    step();
    load_valid = 1'b0;
    step();
    inj_data = 16'hDEAD;
    inj_err  = 1'b1;
    step();
    inj_err = 1'b0;
    @(negedge clk);
    check("err_set", err_unexpected, 1);
    check("err_occupancy", 32'(occupancy), 1);
    check("err_enc_in_valid", enc_in_valid, 1);
    check("err_slot_unchanged", 32'(enc_in_data), 32'h5A5A);
    check("err_out_valid", out_valid, 0);
    repeat (3) step();
    @(negedge clk);
    check("err_sticky", err_unexpected, 1);
    step();
    got_q.delete();
    enc_in_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 1; c++) step();
    check("err_drain_count", got_q.size(), 1);
    if (got_q.size() > 0) check("err_drain_data", 32'(got_q[0]), 32'hFFFF);

    // Random traffic, out_ready toggling 1010.
    got_q.delete();
    n_loaded  = 0;
    n_drained = 0;
    max_occ   = 0;
    for (int c = 0; c < 2000 && n_drained < 100; c++) begin
      if (n_loaded < 100) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = 16'($urandom);
      end else begin
        load_valid = 1'b0;
      end
      enc_in_ready = 1'($urandom_range(0, 1));
      out_ready    = ((c % 2) == 0);
      step();
    end
    load_valid = 1'b0;
    check("rand_drained", n_drained, 100);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_max_occ_le_4", (max_occ <= 4), 1);
    check("rand_err_still_set", err_unexpected, 1);

    // Asynchronous reset with three slots occupied.
    enc_in_ready = 1'b0;
    out_ready    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = 16'(16'h0100 + k);
      step();
    end
    load_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_occupancy", 32'(occupancy), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    enc_q.delete();
    m_occ = 0;
    #1;
    check("async_reset_occupancy", 32'(occupancy), 0);
    check("async_reset_load_ready", load_ready, 1);
    check("async_reset_err", err_unexpected, 0);
    check("async_reset_enc_in_valid", enc_in_valid, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // DEPTH=1 instance: one submatrix every 4 cycles.
    step();
    d1_enc_in_ready = 1'b1;
    d1_out_ready    = 1'b1;
    d1_load_valid   = 1'b1;
    for (int c = 0; c < 200 && d1_drains < 10; c++) begin
      d1_load_data = 16'($urandom);
      step();
    end
    d1_load_valid = 1'b0;
    @(negedge clk);
    check("d1_drains", d1_drains, 10);
    check("d1_occupancy_final", 32'(d1_occupancy), 0);
`ifdef SUBMATRIX_STATS_EN
    exp_stat = 16'd10;
`else
    exp_stat = 16'd0;
`endif
    check("d1_stat_done", 32'(d1_stat_done), 32'(exp_stat));
    check("d1_err", d1_err, 0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
